// File: rtl/ov7670_pkg.sv
// Shared timing defaults, FSM state and pattern encodings for the OV7670 stream generator.
package ov7670_pkg;

  localparam int unsigned DEF_H_ACTIVE = 320;
  localparam int unsigned DEF_BPP      = 2;
  localparam int unsigned DEF_H_BLANK  = 144;
  localparam int unsigned DEF_V_SYNC   = 3;
  localparam int unsigned DEF_V_BACK   = 17;
  localparam int unsigned DEF_V_ACTIVE = 240;
  localparam int unsigned DEF_V_FRONT  = 10;
  localparam int unsigned DEF_ADDR_W   = 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_e;

  typedef enum logic [1:0] {
    PAT_FB    = 2'b00,
    PAT_RAMP  = 2'b01,
    PAT_LINE  = 2'b10,
    PAT_CHECK = 2'b11
  } pattern_e;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned e);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (e > m) m = e;
    return m;
  endfunction

  // Counter width for 0..n-1, never below 4 bits so the checker can read bit 3.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 16) ? 4 : $clog2(n);
  endfunction

endpackage

// File: rtl/ov7670_stream_gen_if.sv
// DVP video pins plus framebuffer read port of the OV7670 stream generator.
interface ov7670_stream_gen_if
  import ov7670_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
);
  logic              fb_rd_en;
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_data;
  logic              vsync;
  logic              href;
  logic [7:0]        d;
  logic              frame_done;

  modport master (
    output fb_rd_en, fb_addr, vsync, href, d, frame_done,
    input  fb_data
  );

  modport slave (
    input  fb_rd_en, fb_addr, vsync, href, d, frame_done,
    output fb_data
  );
endinterface

// File: rtl/ov7670_pattern_src.sv
// Combinational built-in test pattern byte from mode, byte index in line and active line index.
module ov7670_pattern_src
  import ov7670_pkg::*;
#(
  parameter int unsigned BPP = DEF_BPP,
  parameter int unsigned H_W = 10,
  parameter int unsigned V_W = 8
) (
  input  pattern_e       mode_i,
  input  logic [H_W-1:0] byte_idx_i,
  input  logic [V_W-1:0] line_idx_i,
  output logic [7:0]     pat_o
);

  logic pix_bit3;

  always_comb begin
    pix_bit3 = ((byte_idx_i / H_W'(BPP)) & H_W'(8)) != '0;
    pat_o    = '0;
    unique case (mode_i)
      PAT_RAMP:  pat_o = 8'(byte_idx_i);
      PAT_LINE:  pat_o = 8'(line_idx_i);
      PAT_CHECK: pat_o = (pix_bit3 ^ line_idx_i[3]) ? '1 : '0;
      default:   pat_o = '0;
    endcase
  end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670-compatible DVP source: frame FSM, line/pixel counters, framebuffer addressing and
// a 2-stage output pipeline that absorbs the 1-cycle framebuffer read latency.
module ov7670_stream_gen
  import ov7670_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned BPP      = DEF_BPP,
  parameter int unsigned H_BLANK  = DEF_H_BLANK,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input  logic                       pclk_12,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [1:0]                 pattern_sel,
  ov7670_stream_gen_if.master        vid
);

  localparam int unsigned ACT  = H_ACTIVE * BPP;
  localparam int unsigned LINE = ACT + H_BLANK;
  localparam int unsigned H_W  = cnt_w(LINE);
  localparam int unsigned V_W  = cnt_w(max4(V_SYNC, V_BACK, V_ACTIVE, V_FRONT));

  state_e         state_q, state_d;
  logic [H_W-1:0] h_cnt_q, h_cnt_d;
  logic [V_W-1:0] v_cnt_q, v_cnt_d;
  logic           line_end, last_line, frame_start, act_slot, done_slot;

  pattern_e          mode_q;
  logic [ADDR_W-1:0] addr_cnt_q, fb_addr_q;
  logic              fb_rd_en_q, s0_valid_q, s0_vsync_q, s0_done_q;
  logic [H_W-1:0]    s0_byte_q;
  logic [V_W-1:0]    s0_line_q;
  logic [7:0]        pat_byte, s1_pat_q, d_q;
  logic              s1_valid_q, s1_vsync_q, s1_done_q;
  logic              href_q, vsync_q, frame_done_q;

  always_comb begin
    state_d   = state_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    line_end  = (h_cnt_q == H_W'(LINE - 1));
    last_line = 1'b0;
    unique case (state_q)
      ST_VSYNC:  last_line = (v_cnt_q == V_W'(V_SYNC - 1));
      ST_VBACK:  last_line = (v_cnt_q == V_W'(V_BACK - 1));
      ST_ACTIVE: last_line = (v_cnt_q == V_W'(V_ACTIVE - 1));
      ST_VFRONT: last_line = (v_cnt_q == V_W'(V_FRONT - 1));
      default:   last_line = 1'b0;
    endcase

    if (state_q == ST_IDLE) begin
      if (enable) state_d = ST_VSYNC;
    end else begin
      h_cnt_d = line_end ? '0 : h_cnt_q + 1'b1;
      if (line_end) begin
        v_cnt_d = last_line ? '0 : v_cnt_q + 1'b1;
        if (last_line) begin
          unique case (state_q)
            ST_VSYNC:  state_d = ST_VBACK;
            ST_VBACK:  state_d = ST_ACTIVE;
            ST_ACTIVE: state_d = ST_VFRONT;
            ST_VFRONT: state_d = enable ? ST_VSYNC : ST_IDLE;
            default:   state_d = ST_IDLE;
          endcase
        end
      end
    end

    frame_start = (state_d == ST_VSYNC) && (state_q != ST_VSYNC);
    act_slot    = (state_q == ST_ACTIVE) && (h_cnt_q < H_W'(ACT));
    // Slot right after the last active byte, so frame_done trails the last href by one clock.
    done_slot   = (state_q == ST_ACTIVE) && (v_cnt_q == V_W'(V_ACTIVE - 1)) &&
                  (h_cnt_q == H_W'(ACT));
  end

  always_ff @(posedge pclk_12 or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Stage 0: read strobe, address and per-slot side information.
  always_ff @(posedge pclk_12 or posedge reset) begin
    if (reset) begin
      mode_q     <= PAT_FB;
      addr_cnt_q <= '0;
      fb_addr_q  <= '0;
      fb_rd_en_q <= 1'b0;
      s0_valid_q <= 1'b0;
      s0_vsync_q <= 1'b0;
      s0_done_q  <= 1'b0;
      s0_byte_q  <= '0;
      s0_line_q  <= '0;
    end else begin
      fb_rd_en_q <= act_slot && (mode_q == PAT_FB);
      s0_valid_q <= act_slot;
      s0_vsync_q <= (state_q == ST_VSYNC);
      s0_done_q  <= done_slot;
      if (act_slot) begin
        fb_addr_q  <= addr_cnt_q;
        addr_cnt_q <= addr_cnt_q + 1'b1;
        s0_byte_q  <= h_cnt_q;
        s0_line_q  <= v_cnt_q;
      end
      if (frame_start) begin
        mode_q     <= pattern_e'(pattern_sel);
        addr_cnt_q <= '0;
      end
    end
  end

  ov7670_pattern_src #(
    .BPP (BPP),
    .H_W (H_W),
    .V_W (V_W)
  ) u_pattern (
    .mode_i     (mode_q),
    .byte_idx_i (s0_byte_q),
    .line_idx_i (s0_line_q),
    .pat_o      (pat_byte)
  );

  // Stage 1 waits out the framebuffer latency; stage 2 drives the pins.
  always_ff @(posedge pclk_12 or posedge reset) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_vsync_q   <= 1'b0;
      s1_done_q    <= 1'b0;
      s1_pat_q     <= '0;
      href_q       <= 1'b0;
      vsync_q      <= 1'b0;
      frame_done_q <= 1'b0;
      d_q          <= '0;
    end else begin
      s1_valid_q   <= s0_valid_q;
      s1_vsync_q   <= s0_vsync_q;
      s1_done_q    <= s0_done_q;
      s1_pat_q     <= pat_byte;
      href_q       <= s1_valid_q;
      vsync_q      <= s1_vsync_q;
      frame_done_q <= s1_done_q;
      if (!s1_valid_q)           d_q <= '0;
      else if (mode_q == PAT_FB) d_q <= vid.fb_data;
      else                       d_q <= s1_pat_q;
    end
  end

  assign vid.fb_rd_en   = fb_rd_en_q;
  assign vid.fb_addr    = fb_addr_q;
  assign vid.vsync      = vsync_q;
  assign vid.href       = href_q;
  assign vid.d          = d_q;
  assign vid.frame_done = frame_done_q;

endmodule
